// File: rtl/bus_hub_n.sv
// rtl/bus_hub_n.sv - one host port to NUM_DEVICES device ports with registered transaction FSM
//
// Optional feature: define BUS_HUB_TIMEOUT_EN to end a BUSY phase with an error
// response after TIMEOUT_CYCLES cycles without device_ready from the selected device.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   host_*               CPU-side request (level ren/wen) and registered response
//                        (host_ready pulse, host_error qualifier, host_data_read held)
//   device_address/_data_write/_write_mask  request broadcast, one 32/32/4-bit slice per device
//   device_ren/_wen      per-device level strobes, only the selected device
//   device_ready         per-device completion
//   device_data_read     per-device read data, device 0 in the least-significant slice
//   device_active        per-device address decode; lowest active index is selected
module bus_hub_n #(
  parameter int          NUM_DEVICES    = 2,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_RDATA    = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               host_address,
  input  logic [31:0]               host_data_write,
  input  logic [3:0]                host_write_mask,
  input  logic                      host_ren,
  input  logic                      host_wen,
  output logic [31:0]               host_data_read,
  output logic                      host_ready,
  output logic                      host_error,
  output logic [32*NUM_DEVICES-1:0] device_address,
  output logic [32*NUM_DEVICES-1:0] device_data_write,
  output logic [4*NUM_DEVICES-1:0]  device_write_mask,
  output logic [NUM_DEVICES-1:0]    device_ren,
  output logic [NUM_DEVICES-1:0]    device_wen,
  input  logic [NUM_DEVICES-1:0]    device_ready,
  input  logic [32*NUM_DEVICES-1:0] device_data_read,
  input  logic [NUM_DEVICES-1:0]    device_active
);

  localparam int SEL_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

  // Elaboration-time guard on the parameter ranges.
  if (NUM_DEVICES < 1 || NUM_DEVICES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("bus_hub_n: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP,
    ST_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;
  logic             is_wr_q, is_wr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             host_ready_q, host_ready_d;
  logic             host_error_q, host_error_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             hit;
  logic [SEL_W-1:0] sel_hit;
  logic [31:0]      sel_rdata;
  logic [NUM_DEVICES-1:0] sel_onehot;

`ifdef BUS_HUB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] timer_q, timer_d;
  logic [15:0] timer_inc;
  assign timer_inc = timer_q + 16'd1;
`endif

  // Priority decode: scanning downwards leaves the lowest active index.
  always_comb begin
    hit     = 1'b0;
    sel_hit = '0;
    for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
      if (device_active[i]) begin
        hit     = 1'b1;
        sel_hit = SEL_W'(i);
      end
    end
  end

  assign sel_rdata  = device_data_read[32*int'(sel_q) +: 32];
  assign sel_onehot = NUM_DEVICES'(1) << sel_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    is_wr_d      = is_wr_q;
    sel_d        = sel_q;
    host_ready_d = 1'b0;
    host_error_d = 1'b0;
    rdata_d      = rdata_q;
`ifdef BUS_HUB_TIMEOUT_EN
    timer_d      = timer_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (host_ren || host_wen) begin
          addr_d  = host_address;
          wdata_d = host_data_write;
          mask_d  = host_write_mask;
          is_wr_d = host_wen;
          sel_d   = sel_hit;
          if (hit) begin
            state_d = ST_BUSY;
`ifdef BUS_HUB_TIMEOUT_EN
            timer_d = 16'd0;
`endif
          end else begin
            // Decode miss: the error response is registered for the next cycle.
            state_d      = ST_ERR;
            host_ready_d = 1'b1;
            host_error_d = 1'b1;
            rdata_d      = ERROR_RDATA;
          end
        end
      end
      ST_BUSY: begin
        if (device_ready[sel_q]) begin
          state_d      = ST_RESP;
          host_ready_d = 1'b1;
          rdata_d      = is_wr_q ? 32'h0 : sel_rdata;
        end
`ifdef BUS_HUB_TIMEOUT_EN
        // Ready takes precedence over an expiring count.
        else if (timer_inc == TIMEOUT_LIMIT) begin
          state_d      = ST_ERR;
          host_ready_d = 1'b1;
          host_error_d = 1'b1;
          rdata_d      = ERROR_RDATA;
        end else begin
          timer_d = timer_inc;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      is_wr_q      <= 1'b0;
      sel_q        <= '0;
      host_ready_q <= 1'b0;
      host_error_q <= 1'b0;
      rdata_q      <= '0;
`ifdef BUS_HUB_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      is_wr_q      <= is_wr_d;
      sel_q        <= sel_d;
      host_ready_q <= host_ready_d;
      host_error_q <= host_error_d;
      rdata_q      <= rdata_d;
`ifdef BUS_HUB_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  // In IDLE the devices see the live request so they can decode it in the same cycle.
  always_comb begin
    if (state_q == ST_IDLE) begin
      device_address    = {NUM_DEVICES{host_address}};
      device_data_write = {NUM_DEVICES{host_data_write}};
      device_write_mask = {NUM_DEVICES{host_write_mask}};
    end else begin
      device_address    = {NUM_DEVICES{addr_q}};
      device_data_write = {NUM_DEVICES{wdata_q}};
      device_write_mask = {NUM_DEVICES{mask_q}};
    end
  end

  assign device_ren = (state_q == ST_BUSY && !is_wr_q) ? sel_onehot : '0;
  assign device_wen = (state_q == ST_BUSY &&  is_wr_q) ? sel_onehot : '0;

  assign host_ready     = host_ready_q;
  assign host_error     = host_error_q;
  assign host_data_read = rdata_q;

endmodule

// File: doc/bus_hub_n.md
Name: bus_hub_n

Overview:
- Parametrised N-device successor to the fixed two-device bus hub; connects one host port (CPU data bus) to NUM_DEVICES device ports.
- Adds a registered transaction FSM, a synchronous reset, and latched request fields.
- Adds priority decode on device_active, a decode-miss error response and an optional bus timeout.
- Sits between cpu_pipelined's bus port and SoC peripherals (program memory, parallel_output, future UART/timer).

Parameters:
- NUM_DEVICES, 2, number of device ports (1..16); device index 0 occupies the least-significant slice of every packed device_* vector.
- TIMEOUT_CYCLES, 255, BUSY cycles without device ready before a timeout error; range 1..65535 (used only with the optional feature).
- ERROR_RDATA, 32'h0000_0000, value returned on host_data_read for any error response.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- host_address  input  32  byte address
- host_data_write  input  32  write data
- host_write_mask  input  4  byte enables
- host_ren  input  1  read request (level)
- host_wen  input  1  write request (level)
- host_data_read  output  32  read data, registered
- host_ready  output  1  one-cycle completion pulse, registered
- host_error  output  1  qualifies host_ready: decode miss or timeout, registered
- device_address  output  32*NUM_DEVICES  address, broadcast to all devices
- device_data_write  output  32*NUM_DEVICES  write data, broadcast
- device_write_mask  output  4*NUM_DEVICES  byte mask, broadcast
- device_ren  output  NUM_DEVICES  read strobe, selected device only
- device_wen  output  NUM_DEVICES  write strobe, selected device only
- device_ready  input  NUM_DEVICES  per-device done
- device_data_read  input  32*NUM_DEVICES  per-device read data
- device_active  input  NUM_DEVICES  device decodes the presented address

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is synchronous and active-high. On any edge with rst=1:
  - state goes to IDLE;
  - host_ready, host_error, host_data_read, all device strobes and the timeout counter go to 0.
  - rst asserted mid-transaction abandons it: strobes are low from the next cycle and no host_ready is issued.
- Broadcast: device_address, device_data_write and device_write_mask carry the same value on every slice.
  - In IDLE, that value is the live host_* inputs.
  - Otherwise it is the request latched in IDLE.
- IDLE, (host_ren|host_wen)=1:
  - latch address, wdata, mask and op (wen=1 means write, even if ren=1 too);
  - sel = lowest index with device_active=1;
  - if any device is active, go to BUSY, else go to ERR.
- BUSY:
  - device_ren[sel] or device_wen[sel] is held high (level), all others low;
  - device_ready from non-selected devices is ignored;
  - on device_ready[sel]=1, capture device_data_read[sel] (0 for writes) and go to RESP.
- RESP:
  - host_ready=1 for one cycle, host_error=0, host_data_read=captured data;
  - strobes are low;
  - next state is IDLE.
- ERR:
  - host_ready=1 for one cycle, host_error=1, host_data_read=ERROR_RDATA;
  - next state is IDLE.
- host_data_read holds its value until the next response; host_ready and host_error are 0 outside RESP/ERR.
- Latency: request cycle 0 (IDLE). Strobe asserted from cycle 1. Ready at cycle k gives host_ready at k+1.
  - Minimum 3 cycles with a registered-done device (strobe c1, done c2, host_ready c3).
  - Decode miss: host_ready at cycle 1.
- Host rule: the host drops its request the cycle after host_ready, or it is re-accepted as a new transaction.
  - Changes to host_* while BUSY have no effect, because the request is latched.
- Ordering: back-to-back transactions allowed; IDLE is always at least one cycle between them.

Optional Feature:
- Macro BUS_HUB_TIMEOUT_EN.
- Defined:
  - a 16-bit counter clears on entry to BUSY and increments each BUSY cycle without device_ready[sel];
  - when the count reaches TIMEOUT_CYCLES, go to ERR (error response, strobes dropped);
  - ready and timeout in the same cycle: ready wins (normal RESP).
- Undefined: no counter; BUSY waits indefinitely; host_error only ever indicates a decode miss.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with host_ren=1 -> all strobes 0, host_ready=0, host_data_read=0; first strobe appears only after rst=0.
- Read dev1 (N=4, active[1]=1, dev1 returns 32'hCAFE_F00D one cycle after strobe) -> device_ren=4'b0010 for cycles 1–2; host_ready=1, host_error=0, rdata=CAFE_F00D at cycle 3.
- Overlap: active=4'b1010, write addr 0x100, data 0x1234_5678, mask 4'b0011 -> only device_wen[1]=1; all device_address slices=0x100; done; host_error=0.
- Decode miss: active=0, read -> host_ready=1, host_error=1, rdata=ERROR_RDATA at cycle 1; no strobe is ever asserted.
- Timeout (macro defined, TIMEOUT_CYCLES=4, device never ready) -> strobe high 4 cycles, then ERR with host_error=1; a variant with ready on the 4th cycle -> normal RESP.
- Reset mid-BUSY: assert rst while device_ren[0]=1 -> strobe 0 next cycle; a late device_ready is ignored; host_ready stays 0.
